// File: rtl/comp_seq_ctrl.sv
// Serial magnitude comparator: walks two N-bit operands 2 bits per cycle, MSB slice first,
// stops at the first differing slice and reports a registered one-hot x/y/z result with done.
module comp_seq_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         x,
  output logic         y,
  output logic         z
);

  localparam int unsigned S    = N / 2;
  localparam int unsigned CntW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sa_q, sa_d;
  logic [N-1:0]    sb_q, sb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            x_q, x_d;
  logic            y_q, y_d;
  logic            z_q, z_d;

  logic [1:0] slice_a;
  logic [1:0] slice_b;
  logic       accept;

  assign slice_a = sa_q[N-1 -: 2];
  assign slice_b = sb_q[N-1 -: 2];
  assign accept  = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CntW'(S - 1);
          x_d     = 1'b0;
          y_d     = 1'b0;
          z_d     = 1'b0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (slice_a > slice_b) begin
          x_d     = 1'b1;
          state_d = StDone;
        end else if (slice_a < slice_b) begin
          y_d     = 1'b1;
          state_d = StDone;
        end else if (cnt_q == '0) begin
          z_d     = 1'b1;
          state_d = StDone;
        end else begin
          // Equal so far: bring the next lower slice into the compare window.
          sa_d  = sa_q << 2;
          sb_d  = sb_q << 2;
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign x    = x_q;
  assign y    = y_q;
  assign z    = z_q;

  // Result flags never overlap, and a completed compare always carries exactly one.
  a_result_onehot0 : assert property (@(posedge clk) $onehot0({x_q, y_q, z_q}));
  a_done_onehot    : assert property (@(posedge clk) (state_q == StDone) |-> $onehot({x_q, y_q, z_q}));
  a_busy_clear     : assert property (@(posedge clk) (state_q == StRun) |-> ({x_q, y_q, z_q} == 3'b000));

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed bench for comp_seq_ctrl: a table of compares with hand-derived results and
// decision slice, plus hand-written sequences for busy-start, back-to-back and mid-run reset.
module tb_comp_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       x;
  logic       y;
  logic       z;

  int n_checks;
  int n_fail;

  comp_seq_ctrl #(
    .N(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .x    (x),
    .y    (y),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       ex;
    logic       ey;
    logic       ez;
    int         k;    // index of the deciding slice, MSB slice = 0
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one compare from IDLE and follow it through to the cycle after done.
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    bit bad;
    a     = v.va;
    b     = v.vb;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = 8'hxx;
    b     = 8'hxx;
    lat   = 0;
    bad   = 1'b0;
    while (!done && lat < 20) begin
      if (!busy || x || y || z) bad = 1'b1;
      step();
      lat++;
    end
    chk({nm, " latency"}, lat, v.k + 1);
    chk({nm, " busy-with-clear-result"}, {31'd0, bad}, 0);
    chk({nm, " result xyz"}, {29'd0, x, y, z}, {29'd0, v.ex, v.ey, v.ez});
    chk({nm, " busy at done"}, {31'd0, busy}, 0);
    step();
    chk({nm, " done one cycle"}, {30'd0, done, busy}, 0);
    chk({nm, " result held"}, {29'd0, x, y, z}, {29'd0, v.ex, v.ey, v.ez});
  endtask

  initial begin
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;

    vecs[0] = '{va: 8'hA5, vb: 8'hA5, ex: 1'b0, ey: 1'b0, ez: 1'b1, k: 3};
    vecs[1] = '{va: 8'hC0, vb: 8'h40, ex: 1'b1, ey: 1'b0, ez: 1'b0, k: 0};
    vecs[2] = '{va: 8'h12, vb: 8'h13, ex: 1'b0, ey: 1'b1, ez: 1'b0, k: 3};
    vecs[3] = '{va: 8'h00, vb: 8'h00, ex: 1'b0, ey: 1'b0, ez: 1'b1, k: 3};
    vecs[4] = '{va: 8'h00, vb: 8'h80, ex: 1'b0, ey: 1'b1, ez: 1'b0, k: 0};
    vecs[5] = '{va: 8'h34, vb: 8'h38, ex: 1'b0, ey: 1'b1, ez: 1'b0, k: 2};
    vecs[6] = '{va: 8'h0F, vb: 8'h0E, ex: 1'b1, ey: 1'b0, ez: 1'b0, k: 3};
    vecs[7] = '{va: 8'h5A, vb: 8'h6A, ex: 1'b0, ey: 1'b1, ez: 1'b0, k: 1};
    vecs[8] = '{va: 8'hFF, vb: 8'hFE, ex: 1'b1, ey: 1'b0, ez: 1'b0, k: 3};
    vecs[9] = '{va: 8'h9C, vb: 8'h8C, ex: 1'b0, ey: 1'b0, ez: 1'b0, k: 1};
    vecs[9].ex = 1'b1;  // 10 01 11 00 vs 10 00 11 00: slice 1 decides, A larger

    step();
    step();
    chk("reset outputs", {27'd0, busy, done, x, y, z}, 0);
    rst = 1'b0;
    step();
    chk("idle after reset", {27'd0, busy, done, x, y, z}, 0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Result holds through idle cycles without start.
    step();
    step();
    chk("idle hold", {29'd0, x, y, z}, 3'b100);

    // Start pulsed during RUN is ignored.
    a     = 8'h00;
    b     = 8'h00;
    start = 1'b1;
    step();
    start  = 1'b0;
    step();
    a      = 8'hFF;
    b      = 8'h00;
    start  = 1'b1;
    step();
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        chk("busy-start result", {29'd0, x, y, z}, 3'b001);
      end
      step();
    end
    chk("busy-start pulses", pulses, 1);

    // Back-to-back: start held through the DONE cycle.
    a     = 8'h80;
    b     = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b first run", {31'd0, busy}, 1);
    step();
    chk("b2b first done", {28'd0, done, x, y, z}, 4'b1100);
    a     = 8'h00;
    b     = 8'h80;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b accepted", {27'd0, busy, done, x, y, z}, 5'b10000);
    step();
    chk("b2b second done", {27'd0, busy, done, x, y, z}, 5'b01010);
    step();

    // Reset during the second RUN cycle aborts with no done pulse.
    a     = 8'hA5;
    b     = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pre-abort busy", {31'd0, busy}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort state", {27'd0, busy, done, x, y, z}, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) pulses++;
      step();
    end
    chk("abort no activity", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
